// File: rtl/stages_definition_pkg.sv
// rtl/stages_definition_pkg.sv - shared stage definitions: pixel scan-out state and pixel packing helpers
package stages_definition_pkg;

  localparam int PIX_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    SCAN_IDLE  = 3'd0,
    SCAN_FETCH = 3'd1,
    SCAN_WAIT  = 3'd2,
    SCAN_SEND  = 3'd3,
    SCAN_DONE  = 3'd4
  } pix_scan_state;

  // Byte 0 sits in the least significant lane of a packed pixel word.
  function automatic logic [7:0] pix_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - hex digit to 7-segment decoder, segments a..g MSB first, active high
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (hex_i)
      4'h0: seg_o = 7'b1111110;
      4'h1: seg_o = 7'b0110000;
      4'h2: seg_o = 7'b1101101;
      4'h3: seg_o = 7'b1111001;
      4'h4: seg_o = 7'b0110011;
      4'h5: seg_o = 7'b1011011;
      4'h6: seg_o = 7'b1011111;
      4'h7: seg_o = 7'b1110000;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1111011;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b0011111;
      4'hC: seg_o = 7'b1001110;
      4'hD: seg_o = 7'b0111101;
      4'hE: seg_o = 7'b1001111;
      4'hF: seg_o = 7'b1000111;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/pix_scanout.sv
// rtl/pix_scanout.sv - pixel-memory frame reader streaming unpacked 8-bit pixels to the display sink
// PIX_SCANOUT_SEG_EN enables the hex debug display on seg0/seg1/seg2.
module pix_scanout
  import stages_definition_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_data,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              frame_done,
  output logic [6:0]        seg0,
  output logic [6:0]        seg1,
  output logic [6:0]        seg2
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(PIX_BYTES_PER_WORD - 1);

  pix_scan_state     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic              busy_q;
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              pix_valid_q;
  logic [7:0]        pix_data_q;
  logic              pix_sof_q;
  logic              pix_eof_q;
  logic              frame_done_q;

  logic [ADDR_W-1:0] word_idx_d;
  logic [1:0]        byte_idx_d;
  logic              last_word;
  logic              accept;

  assign word_idx_d = word_idx_q + ADDR_W'(1);
  assign byte_idx_d = byte_idx_q + 2'd1;
  assign last_word  = (word_idx_q == LAST_WORD);
  assign accept     = (state_q == SCAN_SEND) && pix_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SCAN_IDLE;
      base_q       <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      word_q       <= 32'd0;
      busy_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 8'd0;
      pix_sof_q    <= 1'b0;
      pix_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mem_rd_en_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        SCAN_IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            word_idx_q  <= '0;
            mem_addr_q  <= base_addr;
            mem_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SCAN_FETCH;
          end
        end
        SCAN_FETCH: begin
          state_q <= SCAN_WAIT;
        end
        SCAN_WAIT: begin
          word_q      <= mem_rd_data;
          byte_idx_q  <= 2'd0;
          pix_valid_q <= 1'b1;
          pix_data_q  <= pix_byte(mem_rd_data, 2'd0);
          pix_sof_q   <= (word_idx_q == '0);
          pix_eof_q   <= 1'b0;
          state_q     <= SCAN_SEND;
        end
        SCAN_SEND: begin
          if (pix_ready) begin
            pix_sof_q <= 1'b0;
            if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_d;
              pix_data_q <= pix_byte(word_q, byte_idx_d);
              pix_eof_q  <= last_word && (byte_idx_d == LAST_BYTE);
            end else begin
              pix_valid_q <= 1'b0;
              pix_eof_q   <= 1'b0;
              if (last_word) begin
                frame_done_q <= 1'b1;
                state_q      <= SCAN_DONE;
              end else begin
                // Address wraps modulo 2^ADDR_W by construction of the adder width.
                word_idx_q  <= word_idx_d;
                mem_addr_q  <= base_q + word_idx_d;
                mem_rd_en_q <= 1'b1;
                state_q     <= SCAN_FETCH;
              end
            end
          end
        end
        SCAN_DONE: begin
          busy_q  <= 1'b0;
          state_q <= SCAN_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          pix_valid_q <= 1'b0;
          state_q     <= SCAN_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eof    = pix_eof_q;
  assign frame_done = frame_done_q;

`ifdef PIX_SCANOUT_SEG_EN
  logic [3:0] seg_lo_q;
  logic [3:0] seg_hi_q;
  logic [3:0] seg_word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_lo_q   <= 4'd0;
      seg_hi_q   <= 4'd0;
      seg_word_q <= 4'd0;
    end else if (accept) begin
      seg_lo_q   <= pix_data_q[3:0];
      seg_hi_q   <= pix_data_q[7:4];
      seg_word_q <= word_idx_q[3:0];
    end
  end

  hex7seg u_seg0 (.hex_i(seg_lo_q),   .seg_o(seg0));
  hex7seg u_seg1 (.hex_i(seg_hi_q),   .seg_o(seg1));
  hex7seg u_seg2 (.hex_i(seg_word_q), .seg_o(seg2));
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign seg0 = 7'b0000000;
  assign seg1 = 7'b0000000;
  assign seg2 = 7'b0000000;
`endif

endmodule

// File: tb/tb_pix_scanout.sv
// tb/tb_pix_scanout.sv - directed self-checking bench for pix_scanout (WORDS=4)
module tb_pix_scanout;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic        busy;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_eof;
  logic        frame_done;
  logic [6:0]  seg0, seg1, seg2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pix_log [64];
  logic        sof_log [64];
  logic        eof_log [64];
  logic [15:0] rd_log  [16];
  int n_pix, n_rd, n_done, n_busy, done_cyc, first_valid_cyc, stall_bad, sof_cnt, eof_cnt;

  pix_scanout #(.ADDR_W(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eof(pix_eof), .frame_done(frame_done),
    .seg0(seg0), .seg1(seg1), .seg2(seg2)
  );

  always #5 clk = ~clk;

  // Memory image: word a holds bytes 4*(a-16)+0..3, except word 0x43 which holds 0xA5 in every lane.
  function automatic logic [31:0] word_at(input logic [15:0] a);
    logic [15:0] t;
    logic [7:0]  b;
    t = a - 16'd16;
    b = {t[5:0], 2'b00};
    if (a == 16'h0043) return 32'hA5A5_A5A5;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [7:0] exp_pix(input logic [15:0] base, input int k);
    logic [15:0] t;
    t = base - 16'd16;
    return {t[5:0], 2'b00} + 8'(k);
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_at(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_eof", pix_eof, 0);
    chk("rst_done", frame_done, 0);
`ifdef PIX_SCANOUT_SEG_EN
    chk("rst_seg", {seg2, seg1, seg0}, {7'b1111110, 7'b1111110, 7'b1111110});
`else
    chk("rst_seg", {seg2, seg1, seg0}, 0);
`endif
  endtask

  // mode 0: pix_ready always high; mode 1: ready toggles every cycle.
  task automatic run_frame(input logic [15:0] base, input int mode, input bit extra_start);
    bit         held;
    logic [7:0] held_data;
    logic       held_sof, held_eof;
    n_pix = 0; n_rd = 0; n_done = 0; n_busy = 0; done_cyc = -1; first_valid_cyc = -1;
    stall_bad = 0; sof_cnt = 0; eof_cnt = 0; held = 0;
    held_data = 8'd0; held_sof = 1'b0; held_eof = 1'b0;
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      pix_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      start = extra_start && (cyc == 5 || cyc == 15);
      if (busy) n_busy++;
      if (mem_rd_en && n_rd < 16) begin rd_log[n_rd] = mem_addr; n_rd++; end
      if (frame_done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (held && (!pix_valid || pix_data !== held_data || pix_sof !== held_sof || pix_eof !== held_eof))
        stall_bad++;
      if (pix_valid && pix_ready) begin
        if (n_pix < 64) begin
          pix_log[n_pix] = pix_data; sof_log[n_pix] = pix_sof; eof_log[n_pix] = pix_eof;
        end
        if (pix_sof) sof_cnt++;
        if (pix_eof) eof_cnt++;
        n_pix++;
        held = 0;
      end else if (pix_valid) begin
        held = 1; held_data = pix_data; held_sof = pix_sof; held_eof = pix_eof;
      end else begin
        held = 0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    pix_ready = 1'b0;
  endtask

  initial begin
    int n_acc;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    // Frame A: base 0x10, ready high, pixels 0x00..0x0F.
    run_frame(16'h0010, 0, 1'b0);
    chk("A_npix", n_pix, 16);
    for (int k = 0; k < 16; k++) chk($sformatf("A_pix%0d", k), pix_log[k], k);
    chk("A_sof_first", sof_log[0], 1);
    chk("A_sof_cnt", sof_cnt, 1);
    chk("A_eof_last", eof_log[15], 1);
    chk("A_eof_cnt", eof_cnt, 1);
    chk("A_done_cnt", n_done, 1);
    chk("A_done_cyc", done_cyc, 24);
    chk("A_busy_cycles", n_busy, 25);
    chk("A_first_valid", first_valid_cyc, 2);
    chk("A_nrd", n_rd, 4);
    for (int w = 0; w < 4; w++) chk($sformatf("A_addr%0d", w), rd_log[w], 16'h0010 + 16'(w));

    // Frame B: ready toggling, stalled pixels must stay stable.
    run_frame(16'h0020, 1, 1'b0);
    chk("B_npix", n_pix, 16);
    for (int k = 0; k < 16; k++) chk($sformatf("B_pix%0d", k), pix_log[k], 8'h40 + 8'(k));
    chk("B_stall_stable", stall_bad, 0);
    chk("B_done_cnt", n_done, 1);
    chk("B_eof_last", eof_log[15], 1);

    // Frame C: address wrap, start pulsed while busy.
    run_frame(16'hFFFD, 0, 1'b1);
    chk("C_nrd", n_rd, 4);
    chk("C_addr0", rd_log[0], 16'hFFFD);
    chk("C_addr2", rd_log[2], 16'hFFFF);
    chk("C_addr3", rd_log[3], 16'h0000);
    chk("C_done_cnt", n_done, 1);
    chk("C_npix", n_pix, 16);
    chk("C_pix0", pix_log[0], exp_pix(16'hFFFD, 0));
    chk("C_pix12", pix_log[12], 8'hC0);
    chk("C_busy_cycles", n_busy, 25);

    // Frame D: last pixel 0xA5 at word 3 drives the debug display.
    run_frame(16'h0040, 0, 1'b0);
    chk("D_pix15", pix_log[15], 8'hA5);
`ifdef PIX_SCANOUT_SEG_EN
    chk("D_seg0", seg0, 7'b1011011);
    chk("D_seg1", seg1, 7'b1110111);
    chk("D_seg2", seg2, 7'b1111001);
`else
    chk("D_seg", {seg2, seg1, seg0}, 0);
`endif

    // Reset in the middle of word 2, byte 1.
    @(negedge clk);
    base_addr = 16'h0010;
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (pix_valid && n_acc == 9) break;
      if (pix_valid) n_acc++;
      @(negedge clk);
    end
    chk("R_before_data", pix_data, 8'h09);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    pix_ready = 1'b0;
    run_frame(16'h0010, 0, 1'b0);
    chk("R_pix0", pix_log[0], 8'h00);
    chk("R_sof0", sof_log[0], 1);
    chk("R_addr0", rd_log[0], 16'h0010);
    chk("R_npix", n_pix, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
